// File: rtl/sccb_target.sv
// ============================================================================
// Module   : sccb_target
// Purpose  : SCCB 2-wire target. Decodes start/stop and 3-phase write,
//            2-phase write and 2-phase read cycles onto an 8-bit register bus.
//            Optional SCCB_TARGET_AUTOINC_EN enables multi-byte bursts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sccb_target #(
    parameter logic [7:0] DEV_ID = 8'h60
) (
    input  logic       XCLK,
    input  logic       RST,
    input  logic       SIO_C,
    input  logic       SIO_D_IN,
    output logic       SIO_D_OUT,
    output logic       SIO_D_OE,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_DC     = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_DC    = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_DC  = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_NA  = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_sc_meta, r_sc_sync, r_sc_prev;
    logic       r_sd_meta, r_sd_sync, r_sd_prev;
    logic [7:0] r_shift, w_shift_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_rep, w_rep_nxt;
    logic [7:0] r_addr, w_addr_nxt;
    logic [7:0] r_wdata, w_wdata_nxt;
    logic       r_we, w_we_nxt;
    logic       r_out, w_out_nxt;
    logic       r_oe, w_oe_nxt;
    logic [7:0] w_byte;

    // Start/stop require SIO_C stable high across both samples, so a
    // simultaneous SIO_C/SIO_D change is never mistaken for one.
    wire w_sc_rise  = r_sc_sync & ~r_sc_prev;
    wire w_sc_fall  = ~r_sc_sync & r_sc_prev;
    wire w_start    = r_sc_sync & r_sc_prev & r_sd_prev & ~r_sd_sync;
    wire w_stop     = r_sc_sync & r_sc_prev & ~r_sd_prev & r_sd_sync;
    wire w_dc_drive = w_sc_fall & ~r_oe;
    wire w_dc_done  = w_sc_fall & r_oe;

    always_ff @(posedge XCLK or negedge RST) begin
        if (!RST) begin
            r_sc_meta <= 1'b1;
            r_sc_sync <= 1'b1;
            r_sc_prev <= 1'b1;
            r_sd_meta <= 1'b1;
            r_sd_sync <= 1'b1;
            r_sd_prev <= 1'b1;
            r_state   <= ST_IDLE;
            r_shift   <= 8'h00;
            r_cnt     <= 4'd0;
            r_rw      <= 1'b0;
            r_rep     <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_we      <= 1'b0;
            r_out     <= 1'b0;
            r_oe      <= 1'b0;
        end else begin
            r_sc_meta <= SIO_C;
            r_sc_sync <= r_sc_meta;
            r_sc_prev <= r_sc_sync;
            r_sd_meta <= SIO_D_IN;
            r_sd_sync <= r_sd_meta;
            r_sd_prev <= r_sd_sync;
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rw      <= w_rw_nxt;
            r_rep     <= w_rep_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_we      <= w_we_nxt;
            r_out     <= w_out_nxt;
            r_oe      <= w_oe_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_rw_nxt    = r_rw;
        w_rep_nxt   = r_rep;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_we_nxt    = 1'b0;
        w_out_nxt   = r_out;
        w_oe_nxt    = r_oe;
        w_byte      = {r_shift[6:0], r_sd_sync};

        if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_oe_nxt    = 1'b0;
            w_out_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ST_ID;
            w_cnt_nxt   = 4'd0;
            w_rep_nxt   = 1'b0;
            w_oe_nxt    = 1'b0;
            w_out_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_ID, ST_SUB, ST_WDATA: begin
                    if (w_sc_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_cnt_nxt = 4'd0;
                            if (r_state == ST_ID) begin
                                w_rw_nxt    = w_byte[0];
                                w_state_nxt = (w_byte[7:1] == DEV_ID[7:1]) ? ST_ID_DC : ST_WAIT_STOP;
                            end else if (r_state == ST_SUB) begin
                                w_addr_nxt  = w_byte;
                                w_state_nxt = ST_SUB_DC;
                            end else begin
                                w_wdata_nxt = w_byte;
                                w_we_nxt    = 1'b1;
                                w_state_nxt = ST_WDATA_DC;
                            end
                        end
                    end
                end
                // Each acknowledge slot: drive 0 on the first falling edge,
                // leave the slot on the second.
                ST_ID_DC: begin
                    if (w_dc_drive) begin
                        w_oe_nxt  = 1'b1;
                        w_out_nxt = 1'b0;
                    end else if (w_dc_done) begin
                        w_cnt_nxt = 4'd0;
                        if (r_rw) begin
                            w_shift_nxt = reg_rdata;
                            w_out_nxt   = reg_rdata[7];
                            w_state_nxt = ST_RDATA;
                        end else begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = ST_SUB;
                        end
                    end
                end
                ST_SUB_DC: begin
                    if (w_dc_drive) begin
                        w_oe_nxt  = 1'b1;
                        w_out_nxt = 1'b0;
                    end else if (w_dc_done) begin
                        w_oe_nxt    = 1'b0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = ST_WDATA;
                    end
                end
                ST_WDATA_DC: begin
                    if (w_dc_drive) begin
                        w_oe_nxt  = 1'b1;
                        w_out_nxt = 1'b0;
                    end else if (w_dc_done) begin
                        w_oe_nxt  = 1'b0;
                        w_cnt_nxt = 4'd0;
`ifdef SCCB_TARGET_AUTOINC_EN
                        w_addr_nxt  = r_addr + 8'd1;
                        w_state_nxt = ST_WDATA;
`else
                        w_state_nxt = ST_WAIT_STOP;
`endif
                    end
                end
                ST_RDATA: begin
                    if (w_sc_rise && (r_cnt != 4'd8)) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_sc_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_out_nxt   = 1'b0;
                            w_rep_nxt   = 1'b0;
                            w_state_nxt = ST_RDATA_NA;
                        end else begin
                            w_out_nxt   = r_shift[6];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_NA: begin
`ifdef SCCB_TARGET_AUTOINC_EN
                    // NA=0: bump the address now so reg_rdata settles before
                    // the reload on the next falling edge.
                    if (w_sc_rise) begin
                        if (r_sd_sync) begin
                            w_state_nxt = ST_WAIT_STOP;
                        end else begin
                            w_addr_nxt = r_addr + 8'd1;
                            w_rep_nxt  = 1'b1;
                        end
                    end else if (w_sc_fall && r_rep) begin
                        w_shift_nxt = reg_rdata;
                        w_out_nxt   = reg_rdata[7];
                        w_oe_nxt    = 1'b1;
                        w_cnt_nxt   = 4'd0;
                        w_rep_nxt   = 1'b0;
                        w_state_nxt = ST_RDATA;
                    end
`else
                    if (w_sc_rise) begin
                        w_state_nxt = ST_WAIT_STOP;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign SIO_D_OUT = r_out;
    assign SIO_D_OE  = r_oe;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sccb_target.sv
// ============================================================================
// Module   : tb_sccb_target
// Purpose  : Randomised self-checking bench for sccb_target with a
//            transaction-level register-file reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sccb_target;

    localparam int HALF = 8;
`ifdef SCCB_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       XCLK = 1'b0;
    logic       RST  = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       line;
    logic       SIO_D_OUT, SIO_D_OE, reg_we, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Register file seen by the target
    logic [7:0]   wr_mem [256];
    logic [255:0] wr_vld = '0;
    logic [15:0]  wlog [4096];
    int           wr_n = 0;
    int           oe_cnt = 0;
    int           busy_lo_cnt = 0;

    // Reference model
    logic [7:0]  model_mem [256];
    logic [7:0]  model_addr = 8'h00;
    logic [15:0] exp_w [$];
    int          rd_idx = 0;

    always #10 XCLK = ~XCLK;

    assign line = m_sda & (SIO_D_OE ? SIO_D_OUT : 1'b1);

    sccb_target #(.DEV_ID(8'h60)) dut (
        .XCLK      (XCLK),
        .RST       (RST),
        .SIO_C     (m_scl),
        .SIO_D_IN  (line),
        .SIO_D_OUT (SIO_D_OUT),
        .SIO_D_OE  (SIO_D_OE),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    function automatic logic [7:0] base_val(input logic [7:0] a);
        if (a == 8'h0A) return 8'hA5;
        return a * 8'd37 + 8'd11;
    endfunction

    assign reg_rdata = wr_vld[reg_addr] ? wr_mem[reg_addr] : base_val(reg_addr);

    always @(negedge XCLK) begin
        if (RST && reg_we) begin
            wr_mem[reg_addr]  <= reg_wdata;
            wr_vld[reg_addr]  <= 1'b1;
            wlog[wr_n]        <= {reg_addr, reg_wdata};
            wr_n              <= wr_n + 1;
        end
        if (SIO_D_OE) oe_cnt <= oe_cnt + 1;
        if (!busy) busy_lo_cnt <= busy_lo_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hc();
        repeat (HALF) @(negedge XCLK);
    endtask

    task automatic clk_bit(input logic b, output logic rd, output logic oe);
        m_sda = b;
        hc();
        m_scl = 1'b1;
        repeat (HALF / 2) @(negedge XCLK);
        rd = line;
        oe = SIO_D_OE;
        repeat (HALF - HALF / 2) @(negedge XCLK);
        m_scl = 1'b0;
    endtask

    task automatic bus_start(input bit from_idle);
        m_sda = 1'b1;
        hc();
        m_scl = 1'b1;
        hc();
        m_sda = 1'b0;
        repeat (2) @(negedge XCLK);
        check_val("busy_pre_start", busy, from_idle ? 32'd0 : 32'd1);
        @(negedge XCLK);
        check_val("busy_start", busy, 1);
        repeat (HALF - 3) @(negedge XCLK);
        m_scl = 1'b0;
        hc();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        hc();
        m_scl = 1'b1;
        hc();
        m_sda = 1'b1;
        repeat (2) @(negedge XCLK);
        check_val("busy_pre_stop", busy, 1);
        @(negedge XCLK);
        check_val("busy_stop", busy, 0);
        repeat (HALF - 3) @(negedge XCLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic rd, oe;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(b[i], rd, oe);
            if (i != 0) hc();
        end
        repeat (2) @(negedge XCLK);
        check_val({tag, "_oe_early"}, SIO_D_OE, 0);
        @(negedge XCLK);
        check_val({tag, "_oe_lat"}, SIO_D_OE, exp_ack);
        repeat (HALF - 3) @(negedge XCLK);
        clk_bit(1'b1, rd, oe);
        check_val({tag, "_ack"}, {oe, rd}, exp_ack ? 32'd2 : 32'd1);
        hc();
    endtask

    task automatic read_byte(input logic na, output logic [7:0] b, output logic rel);
        logic rd, oe;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, rd, oe);
            b[i] = rd;
            hc();
        end
        clk_bit(na, rd, oe);
        rel = ~oe;
        hc();
    endtask

    task automatic check_writes(input string tag);
        check_val({tag, "_wcount"}, wr_n - rd_idx, exp_w.size());
        while (exp_w.size() > 0 && rd_idx < wr_n) begin
            check_val({tag, "_wentry"}, wlog[rd_idx], exp_w.pop_front());
            rd_idx++;
        end
        rd_idx = wr_n;
        exp_w.delete();
    endtask

    task automatic do_write(input logic [7:0] id, input logic [7:0] sub, input int nb, input logic [31:0] dat);
        bit ok;
        ok = (id[7:1] == 7'h30) && !id[0];
        bus_start(1'b1);
        send_byte(id, ok, "id");
        send_byte(sub, ok, "sub");
        if (ok) model_addr = sub;
        for (int i = 0; i < nb; i++) begin
            logic [7:0] d;
            bit ack;
            d   = dat[8*i +: 8];
            ack = ok && (i == 0 || AUTOINC);
            send_byte(d, ack, "wdata");
            if (ack) begin
                exp_w.push_back({model_addr, d});
                model_mem[model_addr] = d;
                if (AUTOINC) model_addr = model_addr + 8'd1;
            end
        end
        bus_stop();
        check_writes("write");
        check_val("addr_after_write", reg_addr, model_addr);
    endtask

    task automatic do_read(input logic [7:0] id, input int nb);
        bit ok;
        logic [7:0] b, exp;
        logic rel;
        ok = (id[7:1] == 7'h30) && id[0];
        bus_start(1'b1);
        send_byte(id, ok, "rid");
        for (int i = 0; i < nb; i++) begin
            read_byte(i == nb - 1, b, rel);
            exp = (ok && (i == 0 || AUTOINC)) ? model_mem[model_addr] : 8'hFF;
            check_val("rdata", b, exp);
            check_val("na_release", rel, 1);
            if (ok && AUTOINC && i != nb - 1) model_addr = model_addr + 8'd1;
        end
        bus_stop();
        check_writes("read");
        check_val("addr_after_read", reg_addr, model_addr);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic rd, oe;
        int s;
        for (int i = 0; i < 256; i++) model_mem[i] = base_val(8'(i));

        repeat (3) @(negedge XCLK);
        check_val("rst_oe", SIO_D_OE, 0);
        check_val("rst_out", SIO_D_OUT, 0);
        check_val("rst_addr", reg_addr, 0);
        check_val("rst_wdata", reg_wdata, 0);
        check_val("rst_we", reg_we, 0);
        check_val("rst_busy", busy, 0);
        RST = 1'b1;
        repeat (5) @(negedge XCLK);

        // 3-phase write
        do_write(8'h60, 8'h12, 1, 32'h80);
        check_val("wdata_hold", reg_wdata, 8'h80);

        // 2-phase write then 2-phase read of the same address
        do_write(8'h60, 8'h0A, 0, 32'h0);
        do_read(8'h61, 1);

        // Foreign ID: never drives
        s = oe_cnt;
        do_write(8'h42, 8'h77, 1, 32'h5A);
        check_val("bad_id_oe", oe_cnt - s, 0);

        // Burst past the top of the address space
        do_write(8'h60, 8'hFE, 4, 32'h44332211);

        // Repeated start inside SUB
        bus_start(1'b1);
        send_byte(8'h60, 1'b1, "id");
        s = busy_lo_cnt;
        for (int i = 0; i < 4; i++) begin
            clk_bit(i[0], rd, oe);
            hc();
        end
        bus_start(1'b0);
        send_byte(8'h60, 1'b1, "id");
        send_byte(8'h33, 1'b1, "sub");
        model_addr = 8'h33;
        send_byte(8'h01, 1'b1, "wdata");
        exp_w.push_back({8'h33, 8'h01});
        model_mem[8'h33] = 8'h01;
        if (AUTOINC) model_addr = model_addr + 8'd1;
        check_val("busy_held", busy_lo_cnt - s, 0);
        bus_stop();
        check_writes("rstart");
        check_val("addr_rstart", reg_addr, model_addr);

        // Reset in the middle of a read while driving
        do_write(8'h60, 8'h55, 0, 32'h0);
        bus_start(1'b1);
        send_byte(8'h61, 1'b1, "rid");
        for (int i = 0; i < 3; i++) begin
            clk_bit(1'b1, rd, oe);
            hc();
        end
        check_val("oe_before_rst", SIO_D_OE, 1);
        RST = 1'b0;
        #1;
        check_val("mid_rst_oe", SIO_D_OE, 0);
        check_val("mid_rst_addr", reg_addr, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_we", reg_we, 0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        model_addr = 8'h00;
        repeat (4) @(negedge XCLK);
        RST = 1'b1;
        repeat (4) @(negedge XCLK);

        // Randomised traffic
        for (int t = 0; t < 20; t++) begin
            logic [7:0] id;
            case ($urandom_range(0, 3))
                0: do_write(8'h60, 8'($urandom), $urandom_range(1, 3), $urandom);
                1: do_write(8'h60, 8'($urandom), 0, 32'h0);
                2: do_read(8'h61, $urandom_range(1, 3));
                default: begin
                    do id = 8'($urandom); while (id[7:1] == 7'h30);
                    if ($urandom_range(0, 1) == 0) do_write(id, 8'($urandom), $urandom_range(0, 2), $urandom);
                    else do_read(id, $urandom_range(1, 2));
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
